// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: data width, queue entry
// layout, pointer width helper and the PC value fetch restarts from after reset.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // One extra bit beyond the index so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: slots are allocated at request issue (tail), filled
// in order as responses return (fill) and popped by decode (head).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_inst,
  input  logic            pop_en,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_inst,
  output logic [PW-1:0]   alloc_cnt,
  output logic [PW-1:0]   pend_cnt,
  output logic            not_empty
);

  localparam int IW = PW - 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   fill;
  logic [PW-1:0]   tail;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
    end else if (clear) begin
      // Everything allocated or filled but not yet popped is abandoned.
      fill <= head;
      tail <= head;
    end else begin
      if (alloc_en) tail <= tail + PW'(1);
      if (fill_en)  fill <= fill + PW'(1);
      if (pop_en)   head <= head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[tail[IW-1:0]]   <= alloc_pc;
    if (fill_en)  inst_mem[fill[IW-1:0]] <= fill_inst;
  end

  assign alloc_cnt = tail - head;
  assign pend_cnt  = tail - fill;
  assign not_empty = (fill != head);
  assign head_pc   = pc_mem[head[IW-1:0]];
  assign head_inst = inst_mem[head[IW-1:0]];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues imem requests from the PC register, queues returned
// words for decode and drops stale responses after a redirect. Optional perf
// counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN    = fetch_pkg::XLEN,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            flush_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_drop_o
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int DW = $clog2(MAX_OUT + 1);
  localparam int CW = PW + DW;

  logic [PW-1:0] alloc_cnt;
  logic [PW-1:0] pend_cnt;
  logic          q_not_empty;
  logic          fill_en;
  logic          pop_en;
  logic [DW-1:0] drop_cnt;
  logic [DW-1:0] drop_flush;
  logic [CW-1:0] occ;
  logic          rsp_hit;

  // occ counts every request still owed a response, kept or dropped.
  always_comb begin
    occ        = CW'(pend_cnt) + CW'(drop_cnt);
    rsp_hit    = imem_rsp_valid_i && (occ != '0);
    drop_flush = DW'(occ - CW'(rsp_hit));
  end

  assign imem_req_valid_o = !rst && !flush_i
                            && (alloc_cnt < PW'(DEPTH))
                            && (occ < CW'(MAX_OUT));
  assign imem_addr_o      = pc_i;
  assign pc_en_o          = imem_req_valid_o && imem_req_ready_i;

  assign fill_en      = imem_rsp_valid_i && !flush_i && (drop_cnt == '0) && (pend_cnt != '0);
  assign inst_valid_o = q_not_empty && !flush_i && !rst;
  assign pop_en       = inst_valid_o && inst_ready_i;

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .alloc_en  (pc_en_o),
    .alloc_pc  (pc_i),
    .fill_en   (fill_en),
    .fill_inst (imem_rsp_data_i),
    .pop_en    (pop_en),
    .head_pc   (inst_pc_o),
    .head_inst (inst_o),
    .alloc_cnt (alloc_cnt),
    .pend_cnt  (pend_cnt),
    .not_empty (q_not_empty)
  );

  // On redirect every outstanding request becomes a drop, less the one whose
  // response is consumed on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush_i) begin
      drop_cnt <= drop_flush;
    end else if (imem_rsp_valid_i && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - DW'(1);
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid_i && (occ == '0)));

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (!inst_valid_o) perf_stall_o <= perf_stall_o + 32'd1;
      if (rsp_hit && (flush_i || (drop_cnt != '0))) perf_drop_o <= perf_drop_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: PC register and imem models drive the DUT,
// a negedge monitor scores every decode handshake against a queue of issued PCs.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_en_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        flush_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_stall_o;
  logic [31:0] perf_drop_o;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .pc_en_o          (pc_en_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .flush_i          (flush_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_stall_o     (perf_stall_o),
    .perf_drop_o      (perf_drop_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] expq[$];
  logic [31:0] out_log[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          lat = 1;
  int          model_drop = 0;
  int          inflight_max = 0;
  int          n_req = 0;
  int          n_out = 0;
  logic [31:0] pc_nx = '0;
  logic [31:0] flush_tgt = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // PC register and memory response driver.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    #1;
    pc_i = pc_nx;
    if (memq.size() != 0 && memq[0].due == edge_n + 1) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = memword(memq[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
  end

  // Monitor: scores outputs, tracks in-flight requests and the expected drop count.
  always @(negedge clk) begin
    int  inflight;
    logic rsp;
    if (rst) begin
      memq.delete();
      expq.delete();
      out_log.delete();
      pc_nx        = 32'h0;
      model_drop   = 0;
      inflight_max = 0;
    end else begin
      chk("drop_cnt", 32'(dut.drop_cnt), model_drop);
      if (inst_valid_o && inst_ready_i) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual_pc=%h expected=none", inst_pc_o);
        end else begin
          chk("out_pc", inst_pc_o, expq[0]);
          chk("out_inst", inst_o, memword(expq[0]));
          void'(expq.pop_front());
        end
        out_log.push_back(inst_pc_o);
        n_out++;
      end
      inflight = memq.size();
      if (inflight > inflight_max) inflight_max = inflight;
      rsp = imem_rsp_valid_i;
      if (rsp) void'(memq.pop_front());
      if (flush_i) begin
        chk("issue_in_flush", imem_req_valid_o, 0);
        chk("out_in_flush", inst_valid_o, 0);
        model_drop = inflight - (rsp ? 1 : 0);
        expq.delete();
        pc_nx = flush_tgt;
      end else begin
        if (rsp && model_drop > 0) model_drop--;
        if (imem_req_valid_o && imem_req_ready_i) begin
          chk("pc_en_fire", pc_en_o, 1);
          chk("req_addr", imem_addr_o, pc_i);
          memq.push_back('{addr: pc_i, due: edge_n + 1 + lat});
          expq.push_back(pc_i);
          n_req++;
          pc_nx = pc_i + 32'd4;
        end else begin
          chk("pc_en_idle", pc_en_o, 0);
        end
      end
    end
  end

  task automatic do_reset(input int k, input logic rdy);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    flush_i      = 1'b0;
    inst_ready_i = rdy;
    lat          = k;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
    int hit;
    hit = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        chk(name, inst_pc_o, exp_pc);
        hit = 1;
        break;
      end
    end
    if (hit == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [31:0] exp_seq [4];
    int found;
    int cnt;
    int n0;
    int hit;
    int exp_drop;
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};

    // Zero-wait memory, decode always ready.
    do_reset(1, 1'b1);
    chk("rst_state_valid", inst_valid_o, 0);
    found = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        found = c;
        break;
      end
    end
    chk("first_valid_cycle", found, 2);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pc_en_o) cnt++;
    end
    chk("pc_en_streak", cnt, 8);
    @(posedge clk);
    #2;
    chk("t1_out_count", out_log.size() >= 4, 1);
    if (out_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t1_out_order", out_log[i], exp_seq[i]);

    // Decode stalled: issue stops at four allocated slots, then drains in order.
    do_reset(1, 1'b0);
    n0 = n_req;
    repeat (12) @(posedge clk);
    #2;
    chk("t2_req_cnt", n_req - n0, 4);
    chk("t2_blocked", imem_req_valid_o, 0);
    inst_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("t2_drain_count", out_log.size() >= 4, 1);
    if (out_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_drain_order", out_log[i], exp_seq[i]);
    chk("t2_resume", n_req - n0 > 4, 1);

    // Latency 3: a slot frees on the response edge and is reusable the next
    // cycle, so each request occupies k+1 = 4 cycles of the 2-deep budget.
    do_reset(3, 1'b1);
    repeat (12) @(posedge clk);
    #2;
    n0 = n_out;
    repeat (32) @(posedge clk);
    #2;
    chk("t3_throughput", n_out - n0, 16);
    chk("t3_max_inflight", inflight_max, 2);

    // Flush with 0x10 and 0x14 outstanding, redirect to 0x100.
    do_reset(3, 1'b1);
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (imem_req_valid_o && imem_addr_o == 32'h14) begin
        hit = 1;
        break;
      end
    end
    chk("t4_reach_0x14", hit, 1);
    @(posedge clk);
    #1;
    flush_tgt = 32'h100;
    flush_i   = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("t4_drop_after_flush", 32'(dut.drop_cnt), 2);
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dut.drop_cnt == '0) begin
        hit = 1;
        break;
      end
    end
    chk("t4_drop_cleared", hit, 1);
    wait_first_pc("t4_first_pc", 32'h100);

    // Flush coinciding with a response and a would-be decode handshake.
    do_reset(2, 1'b0);
    hit      = 0;
    exp_drop = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #2;
      if (memq.size() == 2 && imem_rsp_valid_i && inst_valid_o) begin
        exp_drop     = memq.size() - 1;
        flush_tgt    = 32'h200;
        flush_i      = 1'b1;
        inst_ready_i = 1'b1;
        hit          = 1;
        break;
      end
    end
    chk("t5_setup", hit, 1);
    @(negedge clk);
    chk("t5_no_out_fire", inst_valid_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("t5_drop_pend_m1", 32'(dut.drop_cnt), exp_drop);
    wait_first_pc("t5_first_pc", 32'h200);

    // Reset with a full queue.
    do_reset(1, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    chk("t6_full", imem_req_valid_o, 0);
    chk("t6_valid_before", inst_valid_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", inst_valid_o, 0);
    chk("t6_rst_req", imem_req_valid_o, 0);
    chk("t6_rst_pc_en", pc_en_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_head", 32'(dut.u_queue.head), 0);
    chk("t6_fill", 32'(dut.u_queue.fill), 0);
    chk("t6_tail", 32'(dut.u_queue.tail), 0);
    chk("t6_valid_after", inst_valid_o, 0);
    chk("t6_restart_addr", imem_addr_o, 32'h0);
    chk("t6_restart_req", imem_req_valid_o, 1);
    @(posedge clk);
    #1;
    inst_ready_i = 1'b1;
    wait_first_pc("t6_first_pc", 32'h0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
